// File: rtl/not_bist_pkg.sv
// not_bist_pkg -- shared definitions for the inverter-array BIST engine.
//   state_e        : engine FSM states
//   MIN/MAX_WIDTH  : supported inverter-array widths
//   MODE_GEN/MISR  : not_bist_lfsr mode pin encodings
//   TAPS[w]        : maximal-length feedback mask for a w-bit shift-left
//                    Fibonacci register (feedback enters bit 0)
package not_bist_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_GEN  = 1'b0;
  localparam logic MODE_MISR = 1'b1;

  // Bit k set means stage k+1 of the classic tap list is XORed into feedback.
  localparam logic [MAX_WIDTH-1:0] TAPS [MIN_WIDTH:MAX_WIDTH] = '{
    16'h000C,  //  4: x4+x3+1
    16'h0014,  //  5: x5+x3+1
    16'h0030,  //  6: x6+x5+1
    16'h0060,  //  7: x7+x6+1
    16'h00B8,  //  8: x8+x6+x5+x4+1
    16'h0110,  //  9: x9+x5+1
    16'h0240,  // 10: x10+x7+1
    16'h0500,  // 11: x11+x9+1
    16'h0829,  // 12: x12+x6+x4+x+1
    16'h100D,  // 13: x13+x4+x3+x+1
    16'h2015,  // 14: x14+x5+x3+x+1
    16'h6000,  // 15: x15+x14+1
    16'hD008   // 16: x16+x15+x13+x4+1
  };

endpackage

// File: rtl/not_bist_lfsr.sv
// not_bist_lfsr -- shift-left Fibonacci register, usable as pattern
// generator (mode=MODE_GEN) or signature compactor (mode=MODE_MISR).
//   clk, rst_n : clock, async active-low reset (register <= RST_VAL)
//   mode       : MODE_GEN or MODE_MISR
//   load       : load load_val this cycle (wins over en)
//   en         : advance one step this cycle
//   din        : data folded in when compacting
//   q          : current register contents
//   q_nxt      : value the register takes on the next enabled step
module not_bist_lfsr
  import not_bist_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH][WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d, shifted;

  always_comb begin
    shifted = {q_q[WIDTH-2:0], ^(q_q & TAP_MASK)};
    if (mode == MODE_MISR) begin
      q_nxt = shifted ^ din;
    end else begin
      // The generator must never lock up in the all-zero state.
      q_nxt = (shifted == '0) ? WIDTH'(1) : shifted;
    end
    q_d = q_q;
    if (load)    q_d = load_val;
    else if (en) q_d = q_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/not_bist_engine.sv
// not_bist_engine -- BIST for a WIDTH-bit inverter array: an LFSR drives
// the array, a MISR compacts its outputs over NUM_PATTERNS cycles and the
// result is compared with a golden signature.
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a run (honoured in IDLE only)
//   fault_en/sel/val      : stuck-at injection on one array output bit
//   golden                : expected fault-free signature
//   busy                  : high in SEED and RUN
//   done                  : one-cycle pulse in DONE
//   signature             : MISR contents
//   pass                  : signature == golden, valid from DONE to next start
// Build option: define NOT_BIST_FAULT_INJ_EN to compile in the fault mux;
// otherwise the fault_* inputs are ignored.
module not_bist_engine
  import not_bist_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_PATTERNS = 16,
  parameter int SEED         = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     fault_en,
  input  logic [$clog2(WIDTH)-1:0] fault_sel,
  input  logic                     fault_val,
  input  logic [WIDTH-1:0]         golden,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         signature,
  output logic                     pass
);

  localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);
  // A zero seed would park the generator, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (WIDTH'(SEED) == '0) ? WIDTH'(1) : WIDTH'(SEED);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic [WIDTH-1:0] pattern, arr_o, misr_q, misr_nxt, lfsr_unused_nxt;
  logic             ld, step;

  assign ld   = (state_q == ST_SEED);
  assign step = (state_q == ST_RUN);

  not_bist_lfsr #(.WIDTH(WIDTH), .RST_VAL(SEED_EFF)) u_gen (
    .clk(clk), .rst_n(rst_n), .mode(MODE_GEN), .load(ld), .en(step),
    .load_val(SEED_EFF), .din('0), .q(pattern), .q_nxt(lfsr_unused_nxt)
  );

  not_bist_lfsr #(.WIDTH(WIDTH), .RST_VAL('0)) u_misr (
    .clk(clk), .rst_n(rst_n), .mode(MODE_MISR), .load(ld), .en(step),
    .load_val('0), .din(arr_o), .q(misr_q), .q_nxt(misr_nxt)
  );

  // Inverter array under test, with an optional stuck-at on one output.
  // A fault_sel beyond the array (non power-of-two WIDTH) matches no bit.
  always_comb begin
    arr_o = ~pattern;
`ifdef NOT_BIST_FAULT_INJ_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (fault_en && (int'(fault_sel) == i)) arr_o[i] = fault_val;
    end
`endif
  end

`ifndef NOT_BIST_FAULT_INJ_EN
  logic fault_unused;
  assign fault_unused = ^{fault_en, fault_sel, fault_val};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SEED;
        busy_d  = 1'b1;
      end
      ST_SEED: begin
        state_d = ST_RUN;
        cnt_d   = '0;
        pass_d  = 1'b0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Judge against the value the MISR takes on this final step.
          pass_d  = (misr_nxt == golden);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_not_bist_engine.sv
// Scoreboard bench: drivers push the expected {signature, pass, latency}
// when they issue start; per-instance monitors pop on every done pulse.
// u4: WIDTH=4, NUM_PATTERNS=1, SEED=1.  u8: WIDTH=8, NUM_PATTERNS=16.
module tb_not_bist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef NOT_BIST_FAULT_INJ_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t q4[$], q8[$];
  exp_t e4, e8;
  int   c0_4 = 0, c0_8 = 0;

  // u4 signals
  logic       rst4_n = 1'b0, start4 = 1'b0, fe4 = 1'b0, fv4 = 1'b0;
  logic [1:0] fs4 = '0;
  logic [3:0] gold4 = '0, sig4;
  logic       busy4, done4, pass4;
  // u8 signals
  logic       rst8_n = 1'b0, start8 = 1'b0, fe8 = 1'b0, fv8 = 1'b0;
  logic [2:0] fs8 = '0;
  logic [7:0] gold8 = '0, sig8;
  logic       busy8, done8, pass8;

  not_bist_engine #(.WIDTH(4), .NUM_PATTERNS(1), .SEED(1)) u4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .fault_en(fe4), .fault_sel(fs4),
    .fault_val(fv4), .golden(gold4), .busy(busy4), .done(done4),
    .signature(sig4), .pass(pass4)
  );

  not_bist_engine #(.WIDTH(8), .NUM_PATTERNS(16), .SEED(1)) u8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .fault_en(fe8), .fault_sel(fs8),
    .fault_val(fv8), .golden(gold8), .busy(busy8), .done(done8),
    .signature(sig8), .pass(pass8)
  );

  // Reference 8-bit run: x8+x6+x5+x4+1 generator and compactor.
  function automatic logic [7:0] model8(input logic [7:0] seed, input int n);
    logic [7:0] lf, mi, o;
    lf = seed;
    mi = '0;
    for (int k = 0; k < n; k++) begin
      o  = ~lf;
      mi = {mi[6:0], mi[7] ^ mi[5] ^ mi[4] ^ mi[3]} ^ o;
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      if (lf == 8'h00) lf = 8'h01;
    end
    return mi;
  endfunction

  // Monitors. Latency counts to the rising edge that follows the sample.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("u4 done with nothing pending", done4, 1'b0);
      else begin
        e4 = q4.pop_front();
        check("u4 signature", {4'h0, sig4}, e4.sig);
        check("u4 pass", pass4, e4.pass);
        check("u4 done latency", cyc + 1 - c0_4, e4.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("u8 done with nothing pending", done8, 1'b0);
      else begin
        e8 = q8.pop_front();
        check("u8 signature", sig8, e8.sig);
        check("u8 pass", pass8, e8.pass);
        check("u8 done latency", cyc + 1 - c0_8, e8.lat);
      end
    end
  end

  task automatic run4(input logic fe, input logic [1:0] fs, input logic fv,
                      input logic [3:0] exp_sig, input logic exp_pass);
    int k;
    fe4 = fe; fs4 = fs; fv4 = fv; gold4 = 4'hE;
    q4.push_back('{sig: {4'h0, exp_sig}, pass: exp_pass, lat: 3});
    @(negedge clk); start4 = 1'b1; c0_4 = cyc + 1;
    @(negedge clk); start4 = 1'b0;
    for (k = 0; k < 20 && done4 !== 1'b1; k++) @(negedge clk);
    if (k == 20) check("u4 done timeout", done4, 1'b1);
    @(negedge clk);
    check("u4 done one cycle", done4, 1'b0);
  endtask

  // One u8 run; optionally pulse start again poke cycles into the run.
  task automatic run8(input logic [7:0] exp_sig, input logic exp_pass, input int poke);
    int nb, k;
    q8.push_back('{sig: exp_sig, pass: exp_pass, lat: 18});
    @(negedge clk); start8 = 1'b1; c0_8 = cyc + 1;
    @(negedge clk); start8 = 1'b0;
    nb = 0;
    for (k = 0; k < 100; k++) begin
      if (busy8 === 1'b1) nb++;
      if (done8 === 1'b1) break;
      @(negedge clk);
      start8 = (k + 1 == poke);
    end
    start8 = 1'b0;
    if (k == 100) check("u8 done timeout", done8, 1'b1);
    check("u8 busy cycles", nb, 17);
    @(negedge clk);
    check("u8 done one cycle", done8, 1'b0);
  endtask

  initial begin
    logic [7:0] ref8;
    logic [3:0] sa0_sig, sa1b0_sig;
    logic       sa0_pass, sa1b0_pass;
    ref8       = model8(8'h01, 16);
    sa0_sig    = FI ? 4'hC : 4'hE;
    sa0_pass   = FI ? 1'b0 : 1'b1;
    sa1b0_sig  = FI ? 4'hF : 4'hE;
    sa1b0_pass = FI ? 1'b0 : 1'b1;

    repeat (2) @(negedge clk);
    start4 = 1'b1; start8 = 1'b1;  // must be ignored while in reset
    @(negedge clk);
    check("u4 reset busy", busy4, 1'b0);
    check("u4 reset done", done4, 1'b0);
    check("u4 reset signature", {4'h0, sig4}, 8'h00);
    check("u4 reset pass", pass4, 1'b0);
    check("u8 reset busy", busy8, 1'b0);
    check("u8 reset signature", sig8, 8'h00);
    start4 = 1'b0; start8 = 1'b0;
    rst4_n = 1'b1; rst8_n = 1'b1;
    repeat (3) @(negedge clk);
    check("u4 idle after reset", busy4, 1'b0);
    check("u8 idle after reset", busy8, 1'b0);

    // Single-pattern u4 runs: pattern 0001 -> array 1110.
    run4(1'b0, 2'd1, 1'b0, 4'hE, 1'b1);           // fault-free
    run4(1'b1, 2'd1, 1'b0, sa0_sig, sa0_pass);    // SA0 on bit 1
    // Signature and pass hold in IDLE even if golden moves.
    gold4 = sa0_sig ^ 4'h1;
    repeat (4) @(negedge clk);
    check("u4 hold signature", {4'h0, sig4}, {4'h0, sa0_sig});
    check("u4 hold pass", pass4, sa0_pass);
    run4(1'b1, 2'd1, 1'b1, 4'hE, 1'b1);           // SA1 on a bit already 1
    run4(1'b1, 2'd0, 1'b1, sa1b0_sig, sa1b0_pass);// SA1 on bit 0 (was 0)

    // Full u8 runs: good golden, then a golden one bit off.
    gold8 = ref8;
    run8(ref8, 1'b1, -1);
    gold8 = ref8 ^ 8'h80;
    run8(ref8, 1'b0, -1);

    // Reset during RUN cycle 5.
    gold8 = ref8;
    q8.push_back('{sig: ref8, pass: 1'b1, lat: 18});
    @(negedge clk); start8 = 1'b1; c0_8 = cyc + 1;
    @(negedge clk); start8 = 1'b0;
    repeat (5) @(negedge clk);
    check("u8 busy before reset", busy8, 1'b1);
    rst8_n = 1'b0;
    #1;
    check("u8 mid-run reset busy", busy8, 1'b0);
    check("u8 mid-run reset signature", sig8, 8'h00);
    check("u8 mid-run reset pass", pass8, 1'b0);
    check("u8 mid-run reset done", done8, 1'b0);
    q8.delete();
    @(negedge clk); rst8_n = 1'b1;
    repeat (3) @(negedge clk);
    check("u8 no run after reset release", busy8, 1'b0);
    run8(ref8, 1'b1, -1);

    // Start pulsed during RUN: no effect, one done, same timing.
    run8(ref8, 1'b1, 4);
    repeat (25) @(negedge clk);
    check("u8 no queued run", busy8, 1'b0);
    check("u4 scoreboard drained", q4.size(), 0);
    check("u8 scoreboard drained", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/not_bist_engine.md
NOT_BIST_ENGINE -- requirements
Module: not_bist_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning inverter-array bit count (legal 4..16).
REQ-002 SHALL have parameter NUM_PATTERNS, default 16, meaning pattern count per run (legal 1..65535).
REQ-003 SHALL have parameter SEED, default 1, meaning the LFSR start value (a zero value is replaced by 1).
REQ-004 SHALL have port clk input 1, meaning the single clock, rising edge.
REQ-005 SHALL have port rst_n input 1, meaning the asynchronous active-low reset.
REQ-006 SHALL have port start input 1, meaning a request to begin a run, sampled in IDLE only.
REQ-007 SHALL have port fault_en input 1, meaning an enable for stuck-at injection on the array output.
REQ-008 SHALL have port fault_sel input $clog2(WIDTH), meaning the faulted bit index.
REQ-009 SHALL have port fault_val input 1, meaning the stuck value (0 = SA0, 1 = SA1).
REQ-010 SHALL have port golden input WIDTH, meaning the expected fault-free signature.
REQ-011 SHALL have port busy output 1, meaning high in SEED and RUN.
REQ-012 SHALL have port done output 1, meaning a one-cycle pulse in DONE.
REQ-013 SHALL have port signature output WIDTH, meaning the MISR contents.
REQ-014 SHALL have port pass output 1, meaning signature == golden, valid from DONE until next start.

Function
REQ-015 SHALL implement FSM states IDLE, SEED, RUN and DONE.
REQ-016 SHALL make transitions IDLE->SEED on start, SEED->RUN after 1 cycle, RUN->DONE after NUM_PATTERNS cycles, and DONE->IDLE after 1 cycle.
REQ-017 SHALL, in SEED, load LFSR=SEED, clear MISR to 0, clear pass and clear the pattern counter.
REQ-018 SHALL, on each RUN cycle: pattern=LFSR; o=~pattern with the injected fault applied; MISR<={MISR[WIDTH-2:0], ^(MISR & TAPS[WIDTH])} ^ o; LFSR advances as Fibonacci, same TAPS; counter increments.
REQ-019 SHALL apply fault injection combinationally on o[fault_sel]=fault_val when fault_en=1; fault_sel >= WIDTH SHALL mean no fault.
REQ-020 SHALL sample fault_en, fault_sel and fault_val every RUN cycle; a change mid-run SHALL take effect on the next pattern.
REQ-021 SHALL assert done exactly NUM_PATTERNS+2 cycles after the clk edge that samples start.
REQ-022 SHALL ignore start in SEED, RUN and DONE, with no queuing.
REQ-023 SHALL hold signature and pass in IDLE until the next SEED.
REQ-024 SHALL size the counter to $clog2(NUM_PATTERNS+1) bits, with no wrap before NUM_PATTERNS.
REQ-025 SHALL never let the LFSR reach all-zero; LFSR==0 SHALL be forced to 1.

Reset
REQ-026 SHALL, on rst_n low and at any state including mid-RUN, immediately enter IDLE with busy=0, done=0, pass=0, signature=0, LFSR=SEED and counter=0.
REQ-027 SHALL, after rst_n release, start no run until start is sampled high.

Configuration
REQ-028 SHALL, when macro NOT_BIST_FAULT_INJ_EN is defined, compile in the fault-injection mux (REQ-019/020).
REQ-029 SHALL, when NOT_BIST_FAULT_INJ_EN is undefined, ignore fault_en, fault_sel and fault_val, make o=~pattern always, and keep all ports present.

Structure
REQ-030 SHALL place the FSM state enum, the TAPS[4..16] maximal-length polynomial table and the MIN/MAX_WIDTH constants in package not_bist_pkg.
REQ-031 SHALL implement the LFSR and the MISR as one sub-module, not_bist_lfsr, with a mode pin selecting generator or compactor, instantiated twice.
REQ-032 SHALL keep the inverter array plus fault mux in not_bist_engine as plain combinational logic.

Verification
REQ-033 SHALL cover the fault-free single pattern: WIDTH=4, NUM_PATTERNS=1, SEED=4'h1, fault_en=0, golden=4'hE, start -> done at +3 cycles, signature=4'hE, pass=1.
REQ-034 SHALL cover SA0 injection: same as REQ-033 with fault_en=1, fault_sel=1, fault_val=0 -> signature=4'hC, pass=0.
REQ-035 SHALL cover SA1 on an uncovered value: same as REQ-033 with fault_sel=1, fault_val=1 -> signature=4'hE, pass=1 (fault undetected).
REQ-036 SHALL cover a full run: WIDTH=8, NUM_PATTERNS=16, fault_en=0 -> busy high 17 cycles, done pulse 1 cycle at +18, signature equals the reference model, pass=1 with golden from the model.
REQ-037 SHALL cover reset mid-run: rst_n low at RUN cycle 5 -> same-cycle busy=0, signature=0, pass=0; a new start then completes normally.
REQ-038 SHALL cover start while busy: a pulse during RUN has no effect, done occurs once, and the cycle count is unchanged.
